// File: rtl/io_bus_master_pkg.sv
// Shared widths, bus_ctrl bit layout, size and FSM state encodings for the IO bus master.
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 8
`endif

package io_bus_master_pkg;

    localparam int CTRL_READ     = 0;
    localparam int CTRL_WRITE    = 1;
    localparam int CTRL_STRB_LSB = 2;
    localparam int CTRL_STRB_W   = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Reserved size behaves as word, so it must be word-aligned too.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/io_bus_master_if.sv
// CPU request/response and bus address/control signals of the IO bus master.
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 8
`endif

interface io_bus_master_if;
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_we;
    logic [`IO_BUS_WIDTH_ADDR-1:0] req_addr;
    logic [1:0]                    req_size;
    logic                          req_unsigned;
    logic [`IO_BUS_WIDTH_DATA-1:0] req_wdata;
    logic                          rsp_valid;
    logic [`IO_BUS_WIDTH_DATA-1:0] rsp_rdata;
    logic                          rsp_err;
    logic                          BC;
    logic [`IO_BUS_WIDTH_ADDR-1:0] bus_addr;
    logic [`IO_BUS_WIDTH_CTRL-1:0] bus_ctrl;

    modport master (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, BC, bus_addr, bus_ctrl
    );

    modport slave (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, BC, bus_addr, bus_ctrl
    );
endinterface

// File: rtl/io_bus_lane_align.sv
// Byte-lane strobe, store replication and load extract/extend for a 32-bit bus.
module io_bus_lane_align
    import io_bus_master_pkg::*;
(
    input  logic [1:0]                    i_size,
    input  logic [1:0]                    i_addr_lo,
    input  logic                          i_unsigned,
    input  logic [`IO_BUS_WIDTH_DATA-1:0] i_wdata,
    input  logic [`IO_BUS_WIDTH_DATA-1:0] i_rdata_raw,
    output logic [3:0]                    o_strb,
    output logic [`IO_BUS_WIDTH_DATA-1:0] o_wdata_lanes,
    output logic [`IO_BUS_WIDTH_DATA-1:0] o_rdata_ext
);
    logic [`IO_BUS_WIDTH_DATA-1:0] w_shifted;

    always_comb begin
        o_strb        = 4'b1111;
        o_wdata_lanes = i_wdata;
        w_shifted     = i_rdata_raw;
        o_rdata_ext   = i_rdata_raw;
        case (i_size)
            SIZE_BYTE: begin
                o_strb        = 4'b0001 << i_addr_lo;
                o_wdata_lanes = {4{i_wdata[7:0]}};
                w_shifted     = i_rdata_raw >> {i_addr_lo, 3'b000};
                o_rdata_ext   = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            end
            // Half uses only addr[1]; an odd address truncates rather than spanning lanes.
            SIZE_HALF: begin
                o_strb        = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata_lanes = {2{i_wdata[15:0]}};
                w_shifted     = i_rdata_raw >> {i_addr_lo[1], 4'b0000};
                o_rdata_ext   = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/io_bus_master.sv
// Single-outstanding CPU-to-IO bus master: IDLE/SETUP/ACCESS/WAIT/RESP sequencing.
// Define IO_BUS_MASTER_ALIGN_CHECK_EN to reject misaligned half/word accesses with rsp_err.
module io_bus_master
    import io_bus_master_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    io_bus_master_if.master              bus,
    inout  wire [`IO_BUS_WIDTH_DATA-1:0] bus_data
);
    state_e                        r_state, w_state_nxt;
    logic [2:0]                    r_cnt;
    logic                          r_we, r_unsigned, r_err;
    logic [1:0]                    r_size, r_addr_lo;
    logic [`IO_BUS_WIDTH_DATA-1:0] r_wdata, r_rdata;
    logic [`IO_BUS_WIDTH_ADDR-1:0] r_addr;
    logic                          w_accept, w_misalign, w_wait_done;
    logic                          w_bc, w_drive, w_rsp_valid;
    logic [3:0]                    w_strb;
    logic [`IO_BUS_WIDTH_DATA-1:0] w_wdata_lanes, w_rdata_ext;
    logic [`IO_BUS_WIDTH_CTRL-1:0] w_ctrl;

`ifdef IO_BUS_MASTER_ALIGN_CHECK_EN
    assign w_misalign = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
    assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.req_valid) w_state_nxt = w_misalign ? ST_RESP : ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = r_we ? ST_RESP : ST_WAIT;
            ST_WAIT:   if (w_wait_done) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        w_rsp_valid   = 1'b0;
        w_bc          = 1'b0;
        w_drive       = 1'b0;
        w_ctrl        = '0;
        case (r_state)
            ST_IDLE:   bus.req_ready = !rst;
            ST_SETUP:  w_bc = 1'b1;
            ST_ACCESS: begin
                w_bc    = 1'b1;
                w_drive = r_we;
            end
            ST_WAIT:   w_bc = 1'b1;
            // BC stays up through RESP so back-to-back requests release the bus for one cycle only.
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                w_bc        = !r_err;
            end
            default: ;
        endcase
        if (w_bc) begin
            w_ctrl[CTRL_READ]                        = !r_we;
            w_ctrl[CTRL_WRITE]                       = r_we;
            w_ctrl[CTRL_STRB_LSB +: CTRL_STRB_W]     = w_strb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 3'd0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= 2'd0;
            r_addr_lo  <= 2'd0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_addr     <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= bus.req_we;
                r_unsigned <= bus.req_unsigned;
                r_size     <= bus.req_size;
                r_addr_lo  <= bus.req_addr[1:0];
                r_wdata    <= bus.req_wdata;
                r_err      <= w_misalign;
                r_rdata    <= '0;
                if (!w_misalign) r_addr <= {bus.req_addr[`IO_BUS_WIDTH_ADDR-1:2], 2'b00};
            end
            // Down-counter saturates at zero; terminal count marks the sampling cycle.
            if (r_state == ST_ACCESS)                r_cnt <= 3'(READ_LAT - 1);
            else if (r_state == ST_WAIT && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
            if (w_wait_done) r_rdata <= w_rdata_ext;
        end
    end

    io_bus_lane_align u_lane_align (
        .i_size        (r_size),
        .i_addr_lo     (r_addr_lo),
        .i_unsigned    (r_unsigned),
        .i_wdata       (r_wdata),
        .i_rdata_raw   (bus_data),
        .o_strb        (w_strb),
        .o_wdata_lanes (w_wdata_lanes),
        .o_rdata_ext   (w_rdata_ext)
    );

    assign bus_data      = w_drive ? w_wdata_lanes : 'z;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = w_rsp_valid & r_err;
    assign bus.BC        = w_bc;
    assign bus.bus_ctrl  = w_ctrl;
    assign bus.bus_addr  = r_addr;
endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master with READ_LAT=2 and a cycle-exact device model.
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif

module tb_io_bus_master;
    localparam int LAT = 2;
    localparam logic [31:0] PROBE = 32'h1248_8421;

    logic        clk;
    logic        rst;
    logic        dev_en;
    logic [31:0] dev_val;
    wire  [31:0] bus_data;
    int          n_cmp;
    int          n_mis;

    io_bus_master_if bif ();

    io_bus_master #(.READ_LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif),
        .bus_data (bus_data)
    );

    assign bus_data = dev_en ? dev_val : 'z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] dev;
        logic [7:0]  ctrl;
        logic [31:0] wbus;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // A driving master would corrupt the probe value seen on the wire.
    task automatic probe_z(input string tag);
        dev_val = PROBE;
        dev_en  = 1'b1;
        #1;
        check_eq(tag, bus_data, PROBE);
        dev_en  = 1'b0;
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata, input logic [31:0] dev,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output logic [7:0] ctrl1, output logic [31:0] addr1,
                           output logic [31:0] wbus, output logic bc_seen);
        lat = -1; rdata = '0; err = 1'b0; ctrl1 = '0; addr1 = '0; wbus = '0; bc_seen = 1'b0;
        @(negedge clk);
        check_eq("ready_before_req", 32'(bif.req_ready), 32'd1);
        bif.req_valid    = 1'b1;
        bif.req_we       = we;
        bif.req_addr     = addr;
        bif.req_size     = size;
        bif.req_unsigned = uns;
        bif.req_wdata    = wdata;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bif.req_valid = 1'b0;
                ctrl1 = bif.bus_ctrl;
                addr1 = bif.bus_addr;
            end
            if (c == 2) wbus = bus_data;
            if (bif.BC) bc_seen = 1'b1;
            if (bif.rsp_valid) begin
                lat   = c;
                rdata = bif.rsp_rdata;
                err   = bif.rsp_err;
                dev_en = 1'b0;
                break;
            end
            dev_val = dev;
            dev_en  = !we && (c == 2 + LAT);
        end
        dev_en = 1'b0;
    endtask

    task automatic reset_mid(input logic we, input int at_c, input string tag);
        int n_rsp;
        @(negedge clk);
        bif.req_valid    = 1'b1;
        bif.req_we       = we;
        bif.req_addr     = 32'h0000_0600;
        bif.req_size     = 2'd2;
        bif.req_unsigned = 1'b0;
        bif.req_wdata    = 32'h5555_AAAA;
        for (int c = 1; c <= at_c; c++) begin
            @(negedge clk);
            if (c == 1) bif.req_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_eq({tag, "_bc"},    32'(bif.BC),        32'd0);
        check_eq({tag, "_ctrl"},  32'(bif.bus_ctrl),  32'd0);
        check_eq({tag, "_addr"},  bif.bus_addr,       32'd0);
        check_eq({tag, "_ready"}, 32'(bif.req_ready), 32'd0);
        check_eq({tag, "_rsp"},   32'(bif.rsp_valid), 32'd0);
        check_eq({tag, "_rdata"}, bif.rsp_rdata,      32'd0);
        probe_z({tag, "_z"});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq({tag, "_ready_rel"}, 32'(bif.req_ready), 32'd1);
        n_rsp = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bif.rsp_valid) n_rsp++;
        end
        check_eq({tag, "_no_rsp"}, 32'(n_rsp), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rdata, addr1, wbus, a5, d6;
        logic [7:0]  ctrl1;
        logic        err, bc_seen;
        logic [6:0]  rdy_m, bc_m, rv_m;

        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        dev_en = 1'b0;
        dev_val = '0;
        bif.req_valid = 1'b0;
        bif.req_we = 1'b0;
        bif.req_addr = '0;
        bif.req_size = '0;
        bif.req_unsigned = 1'b0;
        bif.req_wdata = '0;

        //          we    addr          sz    uns   wdata         dev           ctrl   wbus          rdata         lat
        vecs[0] = '{1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0,        8'h3E, 32'hDEAD_BEEF, 32'h0,        3};
        vecs[1] = '{1'b0, 32'hFFFF_F063, 2'd0, 1'b0, 32'h0,         32'h8011_2233, 8'h21, 32'h0,        32'hFFFF_FF80, 5};
        vecs[2] = '{1'b0, 32'h0000_0102, 2'd1, 1'b1, 32'h0,         32'hABCD_1234, 8'h31, 32'h0,        32'h0000_ABCD, 5};
        vecs[3] = '{1'b1, 32'h0000_0001, 2'd0, 1'b0, 32'h1234_56A5, 32'h0,        8'h0A, 32'hA5A5_A5A5, 32'h0,        3};
        vecs[4] = '{1'b1, 32'h0000_0202, 2'd1, 1'b0, 32'hFFFF_1234, 32'h0,        8'h32, 32'h1234_1234, 32'h0,        3};
        vecs[5] = '{1'b0, 32'h0000_0300, 2'd1, 1'b0, 32'h0,         32'h0000_8001, 8'h0D, 32'h0,        32'hFFFF_8001, 5};
        vecs[6] = '{1'b0, 32'h0000_0401, 2'd0, 1'b1, 32'h0,         32'h0000_F000, 8'h09, 32'h0,        32'h0000_00F0, 5};
        vecs[7] = '{1'b0, 32'h0000_0508, 2'd3, 1'b0, 32'h0,         32'h89AB_CDEF, 8'h3D, 32'h0,        32'h89AB_CDEF, 5};

        @(negedge clk);
        check_eq("rst_ready", 32'(bif.req_ready), 32'd0);
        check_eq("rst_bc",    32'(bif.BC),        32'd0);
        check_eq("rst_ctrl",  32'(bif.bus_ctrl),  32'd0);
        check_eq("rst_addr",  bif.bus_addr,       32'd0);
        check_eq("rst_rsp",   32'(bif.rsp_valid), 32'd0);
        check_eq("rst_rdata", bif.rsp_rdata,      32'd0);
        check_eq("rst_err",   32'(bif.rsp_err),   32'd0);
        probe_z("rst_z");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rel_ready", 32'(bif.req_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                    vecs[i].dev, lat, rdata, err, ctrl1, addr1, wbus, bc_seen);
            check_eq($sformatf("v%0d_lat", i),   32'(lat),   32'(vecs[i].lat));
            check_eq($sformatf("v%0d_ctrl", i),  32'(ctrl1), 32'(vecs[i].ctrl));
            check_eq($sformatf("v%0d_addr", i),  addr1,      vecs[i].addr & 32'hFFFF_FFFC);
            check_eq($sformatf("v%0d_rdata", i), rdata,      vecs[i].rdata);
            check_eq($sformatf("v%0d_err", i),   32'(err),   32'd0);
            if (vecs[i].we) check_eq($sformatf("v%0d_wbus", i), wbus, vecs[i].wbus);
            if (vecs[i].we) probe_z($sformatf("v%0d_resp_z", i));
        end

        @(negedge clk);
        check_eq("idle_ctrl", 32'(bif.bus_ctrl), 32'd0);
        check_eq("idle_bc",   32'(bif.BC),       32'd0);
        check_eq("idle_addr", bif.bus_addr,      32'h0000_0508);

        // Back-to-back with req_valid held high.
        bif.req_valid = 1'b1;
        bif.req_we = 1'b1;
        bif.req_addr = 32'h0000_0020;
        bif.req_size = 2'd2;
        bif.req_unsigned = 1'b0;
        bif.req_wdata = 32'h1111_1111;
        rdy_m = '0; bc_m = '0; rv_m = '0; a5 = '0; d6 = '0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            rdy_m[c-1] = bif.req_ready;
            bc_m[c-1]  = bif.BC;
            rv_m[c-1]  = bif.rsp_valid;
            if (c == 5) a5 = bif.bus_addr;
            if (c == 6) d6 = bus_data;
            if (c == 3) begin
                bif.req_addr  = 32'h0000_0024;
                bif.req_wdata = 32'h2222_2222;
            end
            if (c == 5) bif.req_valid = 1'b0;
        end
        check_eq("b2b_ready", 32'(rdy_m), 32'h08);
        check_eq("b2b_bc",    32'(bc_m),  32'h77);
        check_eq("b2b_rsp",   32'(rv_m),  32'h44);
        check_eq("b2b_addr2", a5,         32'h0000_0024);
        check_eq("b2b_data2", d6,         32'h2222_2222);

        reset_mid(1'b0, 3, "rst_wait");
        reset_mid(1'b1, 2, "rst_access");

        run_txn(vecs[0].we, vecs[0].addr, vecs[0].size, vecs[0].uns, vecs[0].wdata,
                vecs[0].dev, lat, rdata, err, ctrl1, addr1, wbus, bc_seen);
        check_eq("after_rst_lat",  32'(lat), 32'd3);
        check_eq("after_rst_wbus", wbus,     32'hDEAD_BEEF);

        run_txn(1'b0, 32'h0000_0006, 2'd2, 1'b0, 32'h0, 32'h1122_3344,
                lat, rdata, err, ctrl1, addr1, wbus, bc_seen);
`ifdef IO_BUS_MASTER_ALIGN_CHECK_EN
        check_eq("mis_lat",   32'(lat),     32'd1);
        check_eq("mis_err",   32'(err),     32'd1);
        check_eq("mis_rdata", rdata,        32'd0);
        check_eq("mis_bc",    32'(bc_seen), 32'd0);
`else
        check_eq("mis_lat",   32'(lat),     32'd5);
        check_eq("mis_err",   32'(err),     32'd0);
        check_eq("mis_rdata", rdata,        32'h1122_3344);
        check_eq("mis_ctrl",  32'(ctrl1),   32'h3D);
        check_eq("mis_addr",  addr1,        32'h0000_0004);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 Parameter READ_LAT, default 1: bus cycles from the ACCESS edge to valid read data on bus_data (range 1..7).
REQ-002 clk  in  1  Single system clock; all state updates on its rising edge.
REQ-003 rst  in  1  Asynchronous, active-high reset.
REQ-004 req_valid  in  1  CPU memory-stage request present.
REQ-005 req_ready  out  1  Master accepts the request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  `IO_BUS_WIDTH_ADDR  Byte address.
REQ-008 req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
REQ-009 req_unsigned  in  1  Zero-extend loads when 1; sign-extend when 0.
REQ-010 req_wdata  in  `IO_BUS_WIDTH_DATA  Store data, LSB-aligned.
REQ-011 rsp_valid  out  1  One-cycle pulse when the transaction is complete.
REQ-012 rsp_rdata  out  `IO_BUS_WIDTH_DATA  Extended load result, valid while rsp_valid is high.
REQ-013 rsp_err  out  1  Misaligned access flag, valid while rsp_valid is high.
REQ-014 BC  out  1  Bus query; high while a transaction occupies the bus.
REQ-015 bus_addr  out  `IO_BUS_WIDTH_ADDR  Word-aligned bus address.
REQ-016 bus_ctrl  out  `IO_BUS_WIDTH_CTRL  Bit0 = read, bit1 = write, bits[5:2] = byte-lane strobe; all other bits are 0.
REQ-017 bus_data  inout  `IO_BUS_WIDTH_DATA  Driven only during write ACCESS; Z at all other times.

Function
REQ-018 The FSM states SHALL be IDLE, SETUP, ACCESS, WAIT and RESP.
- IDLE: req_ready = 1. A cycle with req_valid high latches the request and moves to SETUP.
- SETUP: bus_addr and bus_ctrl are stable; BC = 1.
- ACCESS, write: bus_data is driven; next state is RESP.
- ACCESS, read: next state is WAIT.
- WAIT: counts READ_LAT-1 further cycles, samples bus_data on the final cycle, then moves to RESP.
- RESP: asserts rsp_valid, then returns to IDLE.
REQ-019 req_ready SHALL be high only in IDLE, so there is one outstanding request and no pipelining.
REQ-020 Write latency SHALL be 3 cycles from acceptance to rsp_valid; read latency SHALL be 3+READ_LAT cycles.
REQ-021 Lane strobe: byte gives 4'b0001<<addr[1:0]; half gives 4'b0011<<{addr[1],1'b0}; word gives 4'b1111.
REQ-022 Write data SHALL be replicated onto the lanes: byte as {4{b}}, half as {2{h}}, word unchanged.
REQ-023 Read data SHALL be shifted right by 8*addr[1:0] (byte) or 16*addr[1] (half), then sign- or zero-extended according to req_unsigned.
REQ-024 bus_ctrl SHALL be 0 and bus_addr SHALL hold its last value whenever BC = 0.
REQ-025 For a store, rsp_rdata SHALL be 0.
REQ-026 A req_valid deassertion after acceptance SHALL NOT abort the transaction.
REQ-027 The WAIT counter SHALL be 3 bits, SHALL saturate, and SHALL NOT wrap.

Reset
REQ-028 rst high SHALL asynchronously force the FSM to IDLE and clear the wait counter.
- Forced outputs: BC = 0, bus_ctrl = 0, bus_addr = 0, bus_data = Z.
- Response outputs: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- req_ready = 0 while rst is high, and 1 in the first cycle after release.
REQ-029 Reset mid-transaction SHALL drop the transaction without a response and SHALL release bus_data within the same cycle.

Configuration
REQ-030 With IO_BUS_MASTER_ALIGN_CHECK_EN defined, a misaligned half (addr[0]) or word (addr[1:0] != 0) access SHALL skip SETUP, ACCESS and WAIT, go IDLE->RESP with rsp_err = 1 and rsp_rdata = 0, and never raise BC.
REQ-031 Without IO_BUS_MASTER_ALIGN_CHECK_EN, rsp_err SHALL be tied to 0 and misaligned accesses SHALL proceed with the truncated lane strobe from REQ-021.

Structure
REQ-032 The shared package/param file SHALL hold:
- the bus_ctrl bit positions (READ, WRITE, STRB LSB/width);
- the size encodings;
- the FSM state encodings.
REQ-033 A sub-module io_bus_lane_align SHALL implement the combinational strobe, write replication and read extract/extend; the FSM SHALL remain in io_bus_master.

Verification
REQ-034 The bench SHALL cover these scenarios:
- Word store: addr 0x00000010, data 0xDEADBEEF -> bus_ctrl strobe 1111 with write bit set, bus_data 0xDEADBEEF in ACCESS, rsp_valid 3 cycles after acceptance.
- Byte load, signed, READ_LAT=2: addr 0xFFFFF063, device returns 0x80112233 -> rsp_rdata 0xFFFFFF80, rsp_valid 5 cycles after acceptance.
- Half load, unsigned: addr 0x00000102, bus data 0xABCD1234 -> rsp_rdata 0x0000ABCD, strobe 1100.
- Back-to-back requests with req_valid held high -> the second request is accepted only in the IDLE cycle after RESP; BC drops for exactly that one cycle.
- Reset during WAIT -> no rsp_valid, bus_data Z, BC 0 on the same edge; the next request completes normally.
- With IO_BUS_MASTER_ALIGN_CHECK_EN, word load at addr 0x00000006 -> rsp_err 1 one cycle after acceptance, BC stays 0.
